mux2_rr_arbiter: RTL



---
 rtl/mux2_rr_arbiter_pkg.sv | 14 +
 rtl/mux2_rr_arbiter_if.sv | 29 ++
 rtl/arb_hold_counter.sv | 28 ++
 rtl/mux2_rr_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared encodings for the 2:1 mux round-robin arbiter.
// The optional MUX_ARB_LOCK_EN build adds a grant lock input to the interface.
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Request/grant bundle between the two mux requesters and the arbiter.
// MUX_ARB_LOCK_EN adds a lock input that holds the current grant.
interface mux2_rr_arbiter_if;
    logic req_a;
    logic req_b;
`ifdef MUX_ARB_LOCK_EN
    logic lock;
`endif
    logic gnt_a;
    logic gnt_b;
    logic sel;
    logic busy;

    modport slave (
`ifdef MUX_ARB_LOCK_EN
        input  lock,
`endif
        input  req_a, req_b,
        output gnt_a, gnt_b, sel, busy
    );

    modport master (
`ifdef MUX_ARB_LOCK_EN
        output lock,
`endif
        output req_a, req_b,
        input  gnt_a, gnt_b, sel, busy
    );
endinterface

// File: rtl/arb_hold_counter.sv
// Saturating hold counter: clear wins over enable, stops at MAX-1 and flags it.
module arb_hold_counter #(
    parameter int MAX   = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign term_o = (cnt_q == CNT_W'(MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !term_o)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter driving the select of the shared 2:1 mux, with bounded hold.
// Define MUX_ARB_LOCK_EN to let the owner suppress preemption via bus.lock.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    mux2_rr_arbiter_if.slave bus
);
    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       gnt_a_q, gnt_b_q, sel_q, sel_d;
    logic       cnt_clr, cnt_en, cnt_term;
    logic       lock_w;
    logic       req_a, req_b;

    assign req_a = bus.req_a;
    assign req_b = bus.req_b;

`ifdef MUX_ARB_LOCK_EN
    assign lock_w = bus.lock;
`else
    assign lock_w = 1'b0;
`endif

    arb_hold_counter #(.MAX(HOLD_MAX), .CNT_W(CNT_W)) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_o (cnt_term)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b1;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_a && req_b) state_d = last_q ? ST_GNT_A : ST_GNT_B;
                else if (req_a)     state_d = ST_GNT_A;
                else if (req_b)     state_d = ST_GNT_B;
            end
            ST_GNT_A: begin
                if (!req_a)
                    state_d = req_b ? ST_GNT_B : ST_IDLE;
                else if (lock_w)
                    cnt_clr = 1'b0;          // locked owner: counter frozen, no preemption
                else if (req_b && cnt_term)
                    state_d = ST_GNT_B;
                else if (req_b) begin
                    cnt_clr = 1'b0;
                    cnt_en  = 1'b1;
                end
            end
            ST_GNT_B: begin
                if (!req_b)
                    state_d = req_a ? ST_GNT_A : ST_IDLE;
                else if (lock_w)
                    cnt_clr = 1'b0;
                else if (req_a && cnt_term)
                    state_d = ST_GNT_A;
                else if (req_a) begin
                    cnt_clr = 1'b0;
                    cnt_en  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        last_d = last_q;
        sel_d  = sel_q;
        if (state_d == ST_GNT_A) begin
            last_d = 1'b0;
            sel_d  = SEL_A;
        end else if (state_d == ST_GNT_B) begin
            last_d = 1'b1;
            sel_d  = SEL_B;
        end
    end

    // Outputs come from next state so grant and select move on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            sel_q   <= SEL_A;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_a_q <= (state_d == ST_GNT_A);
            gnt_b_q <= (state_d == ST_GNT_B);
            sel_q   <= sel_d;
        end
    end

    assign bus.gnt_a = gnt_a_q;
    assign bus.gnt_b = gnt_b_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = gnt_a_q | gnt_b_q;
endmodule
